demux_rr_dispatcher: RTL
========================

Name: demux_rr_dispatcher

Overview:
Sequencing controller for the 1-to-8 demux datapath. Accepts a stream of WIDTH-bit words on a valid/ready input and delivers each word to exactly one of NCH output channels. The target channel is either the next channel in round-robin order or an explicit select. Holds one word at a time in a registered stage; all non-target outputs are driven to zero, matching the demux convention.

Parameters:
WIDTH, 8, data word width
SNUM, 3, select width; NCH = 2**SNUM channels (localparam, 8 by default)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
i_data  input  WIDTH  input word
i_valid  input  1  input word valid
i_ready  output  1  dispatcher can accept a word this cycle
mode  input  1  0 = round-robin, 1 = directed; sampled only on input acceptance
i_sel  input  SNUM  target channel in directed mode; sampled on acceptance
o_data  output  NCH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
o_valid  output  NCH  one-hot (or zero) channel valid
o_ready  input  NCH  per-channel sink ready
busy  output  1  word held, not yet delivered
cur_sel  output  SNUM  target of the held word; 0 when idle

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n, sampled at the clk edge.
- Reset values at the first edge with rst_n=0: state=IDLE, rr_ptr=0, o_valid=0, o_data=0, busy=0, cur_sel=0. i_ready is held at 0 while rst_n=0.
- States:
  - IDLE: no word held.
  - SEND: word held in data_q, target in tgt_q.
- i_ready = rst_n && (state==IDLE || (state==SEND && o_ready[tgt_q])). It is combinational from o_ready and is documented as such.
- Acceptance: i_valid && i_ready at an edge. data_q <= i_data and tgt_q <= chosen target; state <= SEND.
- Target selection at acceptance:
  - mode=1: target = i_sel. rr_ptr is unchanged.
  - mode=0: target = rr_ptr, and rr_ptr <= rr_ptr+1 mod NCH.
- Delivery: in SEND, o_valid[tgt_q]=1, o_data slice tgt_q = data_q. All other slices and valids are 0. The word is delivered at an edge where o_ready[tgt_q]=1.
- Delivery with no acceptance at the same edge: state <= IDLE.
- Delivery with acceptance at the same edge (back-to-back): the new word replaces the old one and state stays SEND. Sustained throughput is 1 word/cycle.
- Latency: a word accepted at edge N is visible on o_valid/o_data after edge N. o_data/o_valid are registered (driven from data_q/tgt_q/state only). o_data is 0 when o_valid is 0.
- Backpressure: o_valid and the data are held stable until o_ready[tgt_q] is sampled high. o_ready of non-target channels is ignored.
- busy = (state==SEND); cur_sel = busy ? tgt_q : 0.
- rr_ptr wraps from NCH-1 to 0. Directed transfers never advance it.
- Reset mid-operation: the held word is discarded, no partial delivery occurs, and rr_ptr returns to 0.
- i_valid while i_ready=0: no state change; the upstream source must hold its word.

Optional Feature:
- Macro DEMUX_RR_SKIP_BUSY_EN.
- Defined, mode=0: at acceptance, target = first channel k, scanning from rr_ptr upward mod NCH, with o_ready[k]=1 in that cycle. If none is ready, target = rr_ptr. rr_ptr <= target+1 mod NCH.
- Undefined: strict round-robin as specified above. mode=1 behaviour is identical in both builds.

Decomposition:
- Shared package demux_dispatch_pkg holds:
  - state encoding (IDLE=1'b0, SEND=1'b1)
  - mode encoding constants (MODE_RR=0, MODE_DIR=1)
  - default WIDTH/SNUM.
- One sub-module, rr_pick: combinational first-set search from a start pointer over an NCH-bit vector. It returns the index and a found flag and is instantiated only under DEMUX_RR_SKIP_BUSY_EN.

Test Plan:
1. Reset then strict round-robin: rst_n low 2 cycles, then high. mode=0, o_ready=8'hFF, send 0x10..0x19 back-to-back. Required: i_ready=1 continuously; the words appear on channels 0,1,...,7,0,1 on consecutive cycles; one-hot o_valid; other slices 0.
2. Directed mode: mode=1, i_sel=5, i_data=0xA5, o_ready=8'hFF. Required: o_valid=8'h20 and slice 5 = 0xA5 one cycle after acceptance; rr_ptr unchanged (next mode=0 word goes to the channel rr_ptr held before).
3. Backpressure: mode=0, target channel 2 with o_ready[2]=0 for 4 cycles, other channels ready. Required: o_valid[2] and data held 4 cycles, i_ready=0 and busy=1 throughout. Delivery on the first o_ready[2]=1 edge accepts the queued next word at that same edge.
4. Reset mid-operation: word 0x3C held on channel 4, o_ready=0, rst_n pulsed low 1 cycle. Required: after that edge o_valid=0, o_data=0, busy=0, cur_sel=0, and the next mode=0 word goes to channel 0.
5. Wrap and skip (build with DEMUX_RR_SKIP_BUSY_EN): rr_ptr=6, o_ready=8'b0000_0011. Required: target=0, rr_ptr becomes 1. Without the macro: target=6, held until o_ready[6]=1.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the demux_rr_dispatcher slice.
// Optional busy-skip round-robin is enabled by defining DEMUX_RR_SKIP_BUSY_EN.
package demux_dispatch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_DIR = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SNUM  = 3;

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// rr_pick: combinational first-set search over an NCH-bit vector, starting at a pointer and wrapping.
// Used by demux_rr_dispatcher only when DEMUX_RR_SKIP_BUSY_EN is defined.
module rr_pick #(
    parameter int SNUM = 3
) (
    input  logic [2**SNUM-1:0] vec,
    input  logic [SNUM-1:0]    start,
    output logic [SNUM-1:0]    idx,
    output logic               found
);
    localparam int NCH = 2**SNUM;

    logic [SNUM-1:0] k;

    // Index arithmetic wraps naturally because k is exactly SNUM bits wide.
    always_comb begin
        idx   = start;
        found = 1'b0;
        k     = start;
        for (int i = 0; i < NCH; i++) begin
            k = start + SNUM'(i);
            if (!found && vec[k]) begin
                idx   = k;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: one-word registered stage delivering each word to one of NCH channels.
// Define DEMUX_RR_SKIP_BUSY_EN to let round-robin skip channels not ready at acceptance.
module demux_rr_dispatcher
    import demux_dispatch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SNUM  = DEF_SNUM
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic                       mode,
    input  logic [SNUM-1:0]            i_sel,
    output logic [(2**SNUM)*WIDTH-1:0] o_data,
    output logic [2**SNUM-1:0]         o_valid,
    input  logic [2**SNUM-1:0]         o_ready,
    output logic                       busy,
    output logic [SNUM-1:0]            cur_sel
);
    localparam int NCH = 2**SNUM;

    state_t            state_q, state_d;
    logic [SNUM-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SNUM-1:0]   tgt_q, tgt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SNUM-1:0]   pick_tgt;
    logic              accept;
    logic              deliver;

`ifdef DEMUX_RR_SKIP_BUSY_EN
    logic [SNUM-1:0] skip_idx;
    logic            skip_found;

    rr_pick #(.SNUM(SNUM)) u_rr_pick (
        .vec   (o_ready),
        .start (rr_ptr_q),
        .idx   (skip_idx),
        .found (skip_found)
    );

    assign pick_tgt = skip_found ? skip_idx : rr_ptr_q;
`else
    assign pick_tgt = rr_ptr_q;
`endif

    // i_ready is combinational from o_ready so a delivering word can be replaced in the same cycle.
    always_comb begin
        deliver  = (state_q == SEND) && o_ready[tgt_q];
        i_ready  = rst_n && ((state_q == IDLE) || deliver);
        accept   = i_valid && i_ready;
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        tgt_d    = tgt_q;
        data_d   = data_q;
        if (accept) begin
            state_d = SEND;
            data_d  = i_data;
            if (mode == MODE_DIR) begin
                tgt_d = i_sel;
            end else begin
                tgt_d    = pick_tgt;
                rr_ptr_d = pick_tgt + SNUM'(1);
            end
        end else if (deliver) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            tgt_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            tgt_q    <= tgt_d;
            data_q   <= data_d;
        end
    end

    // Outputs decode only from flops; idle channels read as zero.
    always_comb begin
        o_valid = '0;
        o_data  = '0;
        if (state_q == SEND) begin
            o_valid[tgt_q]                = 1'b1;
            o_data[tgt_q*WIDTH +: WIDTH]  = data_q;
        end
    end

    assign busy    = (state_q == SEND);
    assign cur_sel = busy ? tgt_q : '0;

endmodule
